// File: rtl/serial_addsub_nibble_if.sv
// Handshake and data bundle for the nibble-serial add/subtract engine.
// The requester uses master; the engine uses slave.
`timescale 1ns/1ps
interface serial_addsub_nibble_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic             mode;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             cout;
   logic             overflow;

   modport master (
      output start, mode, a, b,
      input  busy, done, result, cout, overflow
   );

   modport slave (
      input  start, mode, a, b,
      output busy, done, result, cout, overflow
   );
endinterface

// File: rtl/serial_addsub_nibble.sv
// Multi-cycle adder/subtractor: one 4-bit ripple slice reused LSB-first,
// with the inter-nibble carry held in a register.
`timescale 1ns/1ps
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);
   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_addsub_nibble #(
   parameter int WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   serial_addsub_nibble_if.slave bus
);
   localparam int         N    = WIDTH / 4;
   localparam logic [2:0] LAST = 3'(N - 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state;
   state_t           state_next;
   logic             accept;
   logic             finish;

   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic             carry;
   logic [2:0]       count;

   logic [4:0]       c;
   logic [3:0]       slice_sum;
   logic [WIDTH-1:0] assembled;

   logic [WIDTH-1:0] result_q;
   logic             cout_q;
   logic             ovf_q;
   logic             done_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      accept     = 1'b0;
      finish     = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start) begin
               accept     = 1'b1;
               state_next = RUN;
            end
         end
         RUN: begin
            if (count == LAST) begin
               finish     = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // The slice always works on the bottom nibble; operands shift down each step.
   assign c[0] = carry;
   for (genvar i = 0; i < 4; i++) begin : g_slice
      full_adder u_fa (
         .a   (op_a[i]),
         .b   (op_b[i]),
         .cin (c[i]),
         .s   (slice_sum[i]),
         .cout(c[i+1])
      );
   end

   // Completed nibbles enter from the top so the first one ends at bit 0.
   if (WIDTH > 4) begin : g_sum_sr
      logic [WIDTH-5:0] sum_sr;
      assign assembled = {slice_sum, sum_sr};
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n)            sum_sr <= '0;
         else if (state == RUN) sum_sr <= assembled[WIDTH-1:4];
      end
   end else begin : g_single
      assign assembled = slice_sum;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_a     <= '0;
         op_b     <= '0;
         carry    <= 1'b0;
         count    <= '0;
         result_q <= '0;
         cout_q   <= 1'b0;
         ovf_q    <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (accept) begin
            op_a  <= bus.a;
            op_b  <= bus.mode ? ~bus.b : bus.b;
            carry <= bus.mode;
            count <= '0;
         end else if (state == RUN) begin
            op_a  <= op_a >> 4;
            op_b  <= op_b >> 4;
            carry <= c[4];
            count <= count + 3'd1;
            if (finish) begin
               result_q <= assembled;
               cout_q   <= c[4];
               ovf_q    <= c[3] ^ c[4];
               done_q   <= 1'b1;
               count    <= '0;
            end
         end
      end
   end

   assign bus.busy     = (state == RUN);
   assign bus.done     = done_q;
   assign bus.result   = result_q;
   assign bus.cout     = cout_q;
   assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_serial_addsub_nibble.sv
// Self-checking bench for serial_addsub_nibble: directed corner cases plus
// random operations on 32-bit and 4-bit instances against an arithmetic model.
`timescale 1ns/1ps
module tb_serial_addsub_nibble;
   bit   clk;
   logic rst_n;
   int   n_checks;
   int   n_fails;

   serial_addsub_nibble_if #(.WIDTH(32)) bus32 ();
   serial_addsub_nibble_if #(.WIDTH(4))  bus4 ();

   serial_addsub_nibble #(.WIDTH(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));
   serial_addsub_nibble #(.WIDTH(4))  dut4  (.clk(clk), .rst_n(rst_n), .bus(bus4));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   // Reference model: plain unsigned and signed arithmetic on w-bit values.
   function automatic void model(input int w, input logic m,
                                 input longint unsigned x, input longint unsigned y,
                                 output longint unsigned r, output logic c, output logic v);
      longint unsigned span = 64'd1 << w;
      longint          sx   = (x >= span / 2) ? longint'(x) - longint'(span) : longint'(x);
      longint          sy   = (y >= span / 2) ? longint'(y) - longint'(span) : longint'(y);
      longint          st;
      if (!m) begin
         r  = (x + y) % span;
         c  = (x + y) >= span;
         st = sx + sy;
      end else begin
         r  = (x + span - y) % span;
         c  = x >= y;
         st = sx - sy;
      end
      v = (st >= longint'(span / 2)) || (st < -longint'(span / 2));
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic m, input logic [31:0] x, input logic [31:0] y);
      bus32.start = 1'b1;
      bus32.mode  = m;
      bus32.a     = x;
      bus32.b     = y;
      @(posedge clk); #1;
      bus32.start = 1'b0;
      bus32.mode  = 1'($urandom);
      bus32.a     = $urandom;
      bus32.b     = $urandom;
   endtask

   task automatic waitDone32(input int start_lat, output int lat, output logic busy_ok);
      busy_ok = 1'b1;
      lat     = start_lat;
      while (bus32.done !== 1'b1 && lat < 20) begin
         if (bus32.busy !== 1'b1) busy_ok = 1'b0;
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic checkOp32(input string tag, input logic m, input logic [31:0] x,
                            input logic [31:0] y, input int lat, input logic busy_ok);
      longint unsigned r;
      logic            c, v;
      model(32, m, {32'b0, x}, {32'b0, y}, r, c, v);
      checkOutput({tag, "_result"}, 64'(bus32.result), r);
      checkOutput({tag, "_cout"}, 64'(bus32.cout), 64'(c));
      checkOutput({tag, "_overflow"}, 64'(bus32.overflow), 64'(v));
      checkOutput({tag, "_latency"}, 64'(lat), 64'd8);
      checkOutput({tag, "_busy_run"}, 64'(busy_ok), 64'd1);
      checkOutput({tag, "_busy_done"}, 64'(bus32.busy), 64'd0);
   endtask

   task automatic runOp32(input string tag, input logic m, input logic [31:0] x, input logic [31:0] y);
      int   lat;
      logic busy_ok;
      applyStimulus(m, x, y);
      waitDone32(0, lat, busy_ok);
      checkOp32(tag, m, x, y, lat, busy_ok);
   endtask

   task automatic runOp4(input string tag, input logic m, input logic [3:0] x, input logic [3:0] y);
      longint unsigned r;
      logic            c, v;
      model(4, m, {60'b0, x}, {60'b0, y}, r, c, v);
      bus4.start = 1'b1;
      bus4.mode  = m;
      bus4.a     = x;
      bus4.b     = y;
      @(posedge clk); #1;
      bus4.start = 1'b0;
      bus4.a     = 4'($urandom);
      bus4.b     = 4'($urandom);
      checkOutput({tag, "_busy"}, 64'(bus4.busy), 64'd1);
      checkOutput({tag, "_done_early"}, 64'(bus4.done), 64'd0);
      @(posedge clk); #1;
      checkOutput({tag, "_done"}, 64'(bus4.done), 64'd1);
      checkOutput({tag, "_result"}, 64'(bus4.result), r);
      checkOutput({tag, "_cout"}, 64'(bus4.cout), 64'(c));
      checkOutput({tag, "_overflow"}, 64'(bus4.overflow), 64'(v));
      checkOutput({tag, "_busy_done"}, 64'(bus4.busy), 64'd0);
   endtask

   initial begin
      int          lat;
      logic        busy_ok;
      logic        saw_done;
      logic [31:0] ra, rb;
      logic        rm;

      n_checks    = 0;
      n_fails     = 0;
      rst_n       = 1'b1;
      bus32.start = 1'b0;
      bus32.mode  = 1'b0;
      bus32.a     = '0;
      bus32.b     = '0;
      bus4.start  = 1'b0;
      bus4.mode   = 1'b0;
      bus4.a      = '0;
      bus4.b      = '0;
      #1 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_busy", 64'(bus32.busy), 64'd0);
      checkOutput("reset_done", 64'(bus32.done), 64'd0);
      checkOutput("reset_result", 64'(bus32.result), 64'd0);
      checkOutput("reset_cout", 64'(bus32.cout), 64'd0);
      checkOutput("reset_overflow", 64'(bus32.overflow), 64'd0);
      checkOutput("reset_busy4", 64'(bus4.busy), 64'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      $display("[TB] directed add/subtract cases");
      runOp32("add_5_3", 1'b0, 32'h0000_0005, 32'h0000_0003);
      runOp32("sub_5_3", 1'b1, 32'h0000_0005, 32'h0000_0003);
      runOp32("sub_3_5", 1'b1, 32'h0000_0003, 32'h0000_0005);
      runOp32("add_max_pos", 1'b0, 32'h7FFF_FFFF, 32'h0000_0001);
      runOp32("add_wrap", 1'b0, 32'hFFFF_FFFF, 32'h0000_0001);
      runOp32("sub_min_neg", 1'b1, 32'h8000_0000, 32'h0000_0001);
      runOp32("sub_equal", 1'b1, 32'h1234_5678, 32'h1234_5678);

      $display("[TB] start while busy is ignored, then back-to-back");
      applyStimulus(1'b0, 32'h1111_1111, 32'h2222_2222);
      @(posedge clk); #1;
      @(posedge clk); #1;
      bus32.start = 1'b1;
      bus32.mode  = 1'b1;
      bus32.a     = 32'hDEAD_BEEF;
      bus32.b     = 32'h0BAD_F00D;
      @(posedge clk); #1;
      bus32.start = 1'b0;
      waitDone32(3, lat, busy_ok);
      checkOp32("ignored_start", 1'b0, 32'h1111_1111, 32'h2222_2222, lat, busy_ok);
      runOp32("back_to_back", 1'b0, 32'h0000_0010, 32'h0000_0020);

      $display("[TB] random operations");
      for (int i = 0; i < 12; i++) begin
         rm = 1'($urandom);
         ra = $urandom;
         rb = (i % 4 == 0) ? ra : $urandom;
         runOp32("random", rm, ra, rb);
      end

      $display("[TB] reset in the middle of an operation");
      applyStimulus(1'b0, 32'h0F0F_0F0F, 32'h1010_1010);
      repeat (3) begin
         @(posedge clk); #1;
      end
      rst_n = 1'b0;
      #1;
      checkOutput("abort_busy", 64'(bus32.busy), 64'd0);
      checkOutput("abort_done", 64'(bus32.done), 64'd0);
      checkOutput("abort_result", 64'(bus32.result), 64'd0);
      checkOutput("abort_cout", 64'(bus32.cout), 64'd0);
      @(posedge clk); #1;
      rst_n    = 1'b1;
      saw_done = 1'b0;
      repeat (12) begin
         @(posedge clk); #1;
         if (bus32.done === 1'b1 || bus32.busy === 1'b1) saw_done = 1'b1;
      end
      checkOutput("abort_no_done", 64'(saw_done), 64'd0);
      checkOutput("abort_result_held", 64'(bus32.result), 64'd0);
      runOp32("after_abort", 1'b1, 32'h0000_1000, 32'h0000_0001);

      $display("[TB] 4-bit instance");
      runOp4("w4_a_plus_5", 1'b0, 4'hA, 4'h5);
      for (int i = 0; i < 8; i++) begin
         runOp4("w4_random", 1'($urandom), 4'($urandom), 4'($urandom));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end
endmodule
